// File: rtl/rs_alu_station_pkg.sv
// Shared constants for the ALU reservation station: defaults, the "no producer" tag,
// and the bit layout of the {opcode,funct3,funct7} op-code word carried in the name fields.
package rs_alu_station_pkg;

    localparam int RS_SIZE_DEF = 8;
    localparam int TAG_W_DEF   = 4;
    localparam int TAG_NONE    = 0;

    localparam int NAME_F7_LSB  = 0;
    localparam int NAME_F7_W    = 7;
    localparam int NAME_F3_LSB  = 7;
    localparam int NAME_F3_W    = 3;
    localparam int NAME_OPC_LSB = 10;
    localparam int NAME_OPC_W   = 7;

endpackage

// File: rtl/rs_alu_station_pick.sv
// Combinational selector: among requesting entries returns the one with the largest key,
// lowest index winning ties. All-zero keys give plain lowest-index priority.
module rs_pick
    import rs_alu_station_pkg::*;
#(
    parameter int N     = RS_SIZE_DEF,
    parameter int IDX_W = $clog2(RS_SIZE_DEF),
    parameter int KEY_W = 1
) (
    input  logic [N-1:0]       req,
    input  logic [N*KEY_W-1:0] keys,
    output logic [IDX_W-1:0]   idx,
    output logic               hit
);

    logic [KEY_W-1:0] best;

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        best = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (!hit || keys[i*KEY_W +: KEY_W] > best)) begin
                hit  = 1'b1;
                idx  = IDX_W'(i);
                best = keys[i*KEY_W +: KEY_W];
            end
        end
    end

endmodule

// File: rtl/rs_alu_station.sv
// ALU reservation station: buffers issued ops, snoops ROB/LSB broadcasts, dispatches one ready op
// per cycle. Define RS_AGE_SELECT_EN for oldest-first dispatch instead of lowest-index priority.
module rs_alu_station
    import rs_alu_station_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_ready,
    input  logic [31:0]      in_name,
    input  logic [31:0]      in_rd,
    input  logic [31:0]      in_vj,
    input  logic [31:0]      in_vk,
    input  logic [TAG_W-1:0] in_qj,
    input  logic [TAG_W-1:0] in_qk,
    input  logic [31:0]      in_imm,
    input  logic [TAG_W-1:0] in_dest,
    output logic             rs_full,
    input  logic             rob_ready,
    input  logic [TAG_W-1:0] rob_tag,
    input  logic [31:0]      rob_value,
    input  logic             lsb_ready,
    input  logic [TAG_W-1:0] lsb_tag,
    input  logic [31:0]      lsb_value,
    input  logic             alu_ready,
    output logic             ex_valid,
    output logic [31:0]      ex_name,
    output logic [31:0]      ex_rd,
    output logic [31:0]      ex_vj,
    output logic [31:0]      ex_vk,
    output logic [31:0]      ex_imm,
    output logic [TAG_W-1:0] ex_dest
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam logic [TAG_W-1:0] TAG_Z = TAG_W'(TAG_NONE);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] busy_n;
    logic [RS_SIZE-1:0] eligible;
    logic [31:0]        e_name [RS_SIZE];
    logic [31:0]        e_rd   [RS_SIZE];
    logic [31:0]        e_vj   [RS_SIZE];
    logic [31:0]        e_vk   [RS_SIZE];
    logic [31:0]        e_imm  [RS_SIZE];
    logic [TAG_W-1:0]   e_qj   [RS_SIZE];
    logic [TAG_W-1:0]   e_qk   [RS_SIZE];
    logic [TAG_W-1:0]   e_dest [RS_SIZE];

    logic [IDX_W-1:0] sel_idx;
    logic             sel_hit;
    logic [IDX_W-1:0] free_idx;
    logic             free_hit;
    logic             issue;
    logic             dispatch;

    // ROB beats LSB when both carry the awaited tag.
    function automatic logic [TAG_W+31:0] snoop(input logic [TAG_W-1:0] q, input logic [31:0] v);
        logic [TAG_W+31:0] r;
        r = {q, v};
        if (q != TAG_Z) begin
            if (rob_ready && rob_tag == q)
                r = {TAG_Z, rob_value};
            else if (lsb_ready && lsb_tag == q)
                r = {TAG_Z, lsb_value};
        end
        return r;
    endfunction

`ifdef RS_AGE_SELECT_EN
    localparam int KEY_W = IDX_W + 1;
    logic [KEY_W-1:0]         age_cnt;
    logic [KEY_W-1:0]         e_stamp [RS_SIZE];
    logic [RS_SIZE*KEY_W-1:0] sel_keys;

    // Distance back from the issue counter: larger means issued earlier.
    always_comb begin
        sel_keys = '0;
        for (int i = 0; i < RS_SIZE; i++)
            sel_keys[i*KEY_W +: KEY_W] = age_cnt - e_stamp[i];
    end

    always_ff @(posedge clk) begin
        if (rst)
            age_cnt <= '0;
        else if (rdy && !flush)
            age_cnt <= age_cnt + KEY_W'(issue);
    end
`else
    localparam int KEY_W = 1;
    logic [RS_SIZE*KEY_W-1:0] sel_keys;
    assign sel_keys = '0;
`endif

    always_comb begin
        eligible = '0;
        for (int i = 0; i < RS_SIZE; i++)
            eligible[i] = busy[i] && e_qj[i] == TAG_Z && e_qk[i] == TAG_Z;
    end

    rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W), .KEY_W(KEY_W)) u_sel (
        .req  (alu_ready ? eligible : '0),
        .keys (sel_keys),
        .idx  (sel_idx),
        .hit  (sel_hit)
    );

    rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W), .KEY_W(1)) u_free (
        .req  (~busy),
        .keys ('0),
        .idx  (free_idx),
        .hit  (free_hit)
    );

    assign rs_full  = &busy;
    assign issue    = rdy && !flush && in_ready && !rs_full && free_hit;
    assign dispatch = rdy && !flush && sel_hit;

    always_comb begin
        busy_n = busy;
        if (dispatch)
            busy_n[sel_idx] = 1'b0;
        if (issue)
            busy_n[free_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            ex_valid <= 1'b0;
            ex_name  <= '0;
            ex_rd    <= '0;
            ex_vj    <= '0;
            ex_vk    <= '0;
            ex_imm   <= '0;
            ex_dest  <= '0;
        end else if (!rdy) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            busy     <= '0;
            ex_valid <= 1'b0;
            ex_name  <= '0;
            ex_rd    <= '0;
            ex_vj    <= '0;
            ex_vk    <= '0;
            ex_imm   <= '0;
            ex_dest  <= '0;
        end else begin
            busy     <= busy_n;
            ex_valid <= dispatch;
            if (dispatch) begin
                ex_name <= e_name[sel_idx];
                ex_rd   <= e_rd[sel_idx];
                ex_vj   <= e_vj[sel_idx];
                ex_vk   <= e_vk[sel_idx];
                ex_imm  <= e_imm[sel_idx];
                ex_dest <= e_dest[sel_idx];
            end
        end
    end

    // Entry payload needs no reset: busy qualifies every use of it.
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    {e_qj[i], e_vj[i]} <= snoop(e_qj[i], e_vj[i]);
                    {e_qk[i], e_vk[i]} <= snoop(e_qk[i], e_vk[i]);
                end
            end
            if (issue) begin
                e_name[free_idx] <= in_name;
                e_rd[free_idx]   <= in_rd;
                e_imm[free_idx]  <= in_imm;
                e_dest[free_idx] <= in_dest;
                {e_qj[free_idx], e_vj[free_idx]} <= snoop(in_qj, in_vj);
                {e_qk[free_idx], e_vk[free_idx]} <= snoop(in_qk, in_vk);
`ifdef RS_AGE_SELECT_EN
                e_stamp[free_idx] <= age_cnt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rs_alu_station.sv
// Bench for rs_alu_station: directed scenarios plus randomized traffic against a slot-level model.
module tb_rs_alu_station;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_ready;
    logic [31:0] in_name, in_rd, in_vj, in_vk, in_imm;
    logic [3:0]  in_qj, in_qk, in_dest;
    logic        rs_full;
    logic        rob_ready, lsb_ready, alu_ready;
    logic [3:0]  rob_tag, lsb_tag;
    logic [31:0] rob_value, lsb_value;
    logic        ex_valid;
    logic [31:0] ex_name, ex_rd, ex_vj, ex_vk, ex_imm;
    logic [3:0]  ex_dest;

    int passed = 0;
    int total  = 0;

    rs_alu_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_ready(in_ready),
        .in_name(in_name), .in_rd(in_rd), .in_vj(in_vj), .in_vk(in_vk),
        .in_qj(in_qj), .in_qk(in_qk), .in_imm(in_imm), .in_dest(in_dest),
        .rs_full(rs_full), .rob_ready(rob_ready), .rob_tag(rob_tag), .rob_value(rob_value),
        .lsb_ready(lsb_ready), .lsb_tag(lsb_tag), .lsb_value(lsb_value),
        .alu_ready(alu_ready), .ex_valid(ex_valid), .ex_name(ex_name), .ex_rd(ex_rd),
        .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_imm(ex_imm), .ex_dest(ex_dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy;
        logic [31:0] name, rd, vj, vk, imm;
        logic [3:0]  qj, qk, dest;
    } slot_t;

    slot_t       m [8];
    logic        m_valid = 1'b0;
    logic [31:0] m_name = '0, m_rd = '0, m_vj = '0, m_vk = '0, m_imm = '0;
    logic [3:0]  m_dest = '0;

    task automatic snoop(input logic [3:0] q, input logic [31:0] v,
                         output logic [3:0] qo, output logic [31:0] vo);
        qo = q;
        vo = v;
        if (q != 4'd0) begin
            if (rob_ready && rob_tag == q) begin
                qo = 4'd0;
                vo = rob_value;
            end else if (lsb_ready && lsb_tag == q) begin
                qo = 4'd0;
                vo = lsb_value;
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m[i].busy = 0;
        m_valid = 0;
        m_name = '0; m_rd = '0; m_vj = '0; m_vk = '0; m_imm = '0; m_dest = '0;
    endtask

    // Next-cycle behaviour from the current inputs, applied just before the clock edge.
    task automatic model_step();
        int  sel, free;
        bit  full;
        if (rst || (rdy && flush)) begin
            clear_model();
        end else if (!rdy) begin
            m_valid = 0;
        end else begin
            full = 1;
            sel  = -1;
            free = -1;
            for (int i = 0; i < 8; i++) begin
                if (!m[i].busy) full = 0;
                if (!m[i].busy && free < 0) free = i;
                if (alu_ready && sel < 0 && m[i].busy && m[i].qj == 0 && m[i].qk == 0) sel = i;
            end
            m_valid = (sel >= 0);
            if (sel >= 0) begin
                m_name = m[sel].name; m_rd = m[sel].rd; m_vj = m[sel].vj;
                m_vk = m[sel].vk; m_imm = m[sel].imm; m_dest = m[sel].dest;
                m[sel].busy = 0;
            end
            for (int i = 0; i < 8; i++) begin
                if (m[i].busy) begin
                    snoop(m[i].qj, m[i].vj, m[i].qj, m[i].vj);
                    snoop(m[i].qk, m[i].vk, m[i].qk, m[i].vk);
                end
            end
            if (in_ready && !full) begin
                m[free].busy = 1;
                m[free].name = in_name; m[free].rd = in_rd; m[free].imm = in_imm;
                m[free].dest = in_dest;
                snoop(in_qj, in_vj, m[free].qj, m[free].vj);
                snoop(in_qk, in_vk, m[free].qk, m[free].vk);
            end
        end
    endtask

    function automatic bit model_full();
        bit f = 1;
        for (int i = 0; i < 8; i++) if (!m[i].busy) f = 0;
        return f;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst = 0; rdy = 1; flush = 0; in_ready = 0;
        in_name = '0; in_rd = '0; in_vj = '0; in_vk = '0; in_imm = '0;
        in_qj = '0; in_qk = '0; in_dest = '0;
        rob_ready = 0; rob_tag = '0; rob_value = '0;
        lsb_ready = 0; lsb_tag = '0; lsb_value = '0;
    endtask

    task automatic set_issue(input logic [31:0] vj, input logic [3:0] qj,
                             input logic [31:0] imm, input logic [3:0] dest);
        in_ready = 1; in_name = 32'h0000_4c13; in_rd = 32'h0000_0100 + dest;
        in_vj = vj; in_qj = qj; in_vk = 32'h55; in_qk = 4'd0; in_imm = imm; in_dest = dest;
    endtask

    task automatic test_reset();
        drive_idle();
        alu_ready = 1;
        rst = 1;
        tick();
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got=%0b want=0", ex_valid); else passed++;
        total++; if (rs_full !== 1'b0) $display("FAIL reset_rs_full got=%0b want=0", rs_full); else passed++;
        total++; if (ex_vj !== 32'd0) $display("FAIL reset_ex_vj got=%h want=0", ex_vj); else passed++;
        rst = 0;
    endtask

    task automatic test_basic();
        drive_idle(); alu_ready = 1;
        set_issue(32'd5, 4'd0, 32'd3, 4'd1);
        tick();
        drive_idle();
        total++; if (ex_valid !== 1'b0) $display("FAIL basic_early got=%0b want=0", ex_valid); else passed++;
        tick();
        total++; if (ex_valid !== 1'b1) $display("FAIL basic_valid got=%0b want=1", ex_valid); else passed++;
        total++; if (ex_vj !== 32'd5 || ex_imm !== 32'd3) $display("FAIL basic_data vj=%0d imm=%0d want 5 3", ex_vj, ex_imm); else passed++;
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL basic_pulse got=%0b want=0", ex_valid); else passed++;
    endtask

    task automatic test_rob_wakeup();
        drive_idle(); alu_ready = 1;
        set_issue(32'd0, 4'd3, 32'd9, 4'd2);
        tick();
        drive_idle();
        tick();
        rob_ready = 1; rob_tag = 4'd3; rob_value = 32'h1234;
        tick();
        drive_idle();
        total++; if (ex_valid !== 1'b0) $display("FAIL rob_wake_early got=%0b want=0", ex_valid); else passed++;
        tick();
        total++; if (ex_valid !== 1'b1 || ex_vj !== 32'h1234) $display("FAIL rob_wake v=%0b vj=%h want 1 1234", ex_valid, ex_vj); else passed++;
        tick();
    endtask

    task automatic test_issue_forward();
        drive_idle(); alu_ready = 1;
        set_issue(32'd0, 4'd2, 32'd1, 4'd4);
        lsb_ready = 1; lsb_tag = 4'd2; lsb_value = 32'd7;
        tick();
        drive_idle();
        tick();
        total++; if (ex_valid !== 1'b1 || ex_vj !== 32'd7) $display("FAIL issue_fwd v=%0b vj=%h want 1 7", ex_valid, ex_vj); else passed++;
        // ROB wins over LSB when both carry the tag on the issue cycle.
        set_issue(32'd0, 4'd6, 32'd1, 4'd5);
        rob_ready = 1; rob_tag = 4'd6; rob_value = 32'hA0;
        lsb_ready = 1; lsb_tag = 4'd6; lsb_value = 32'hB0;
        tick();
        drive_idle();
        tick();
        total++; if (ex_valid !== 1'b1 || ex_vj !== 32'hA0) $display("FAIL fwd_rob_prio v=%0b vj=%h want 1 a0", ex_valid, ex_vj); else passed++;
        tick();
    endtask

    task automatic test_full();
        drive_idle(); alu_ready = 1;
        for (int i = 0; i < 8; i++) begin
            set_issue(32'd0, 4'd5, 32'd0, 4'(i + 1));
            tick();
        end
        total++; if (rs_full !== 1'b1) $display("FAIL full_set got=%0b want=1", rs_full); else passed++;
        set_issue(32'd0, 4'd0, 32'd0, 4'd9);
        tick();
        drive_idle();
        total++; if (rs_full !== 1'b1 || ex_valid !== 1'b0) $display("FAIL full_drop full=%0b v=%0b want 1 0", rs_full, ex_valid); else passed++;
        rob_ready = 1; rob_tag = 4'd5; rob_value = 32'hAA;
        tick();
        drive_idle();
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (ex_valid !== 1'b1 || ex_dest !== 4'(k + 1) || ex_vj !== 32'hAA)
                $display("FAIL full_drain%0d v=%0b dest=%0d vj=%h want 1 %0d aa", k, ex_valid, ex_dest, ex_vj, k + 1);
            else passed++;
            if (k == 0) begin
                total++; if (rs_full !== 1'b0) $display("FAIL full_release got=%0b want=0", rs_full); else passed++;
            end
        end
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL full_ninth got=%0b want=0", ex_valid); else passed++;
    endtask

    task automatic test_alu_stall();
        drive_idle(); alu_ready = 0;
        set_issue(32'd1, 4'd0, 32'd0, 4'd3);
        tick();
        set_issue(32'd2, 4'd0, 32'd0, 4'd4);
        tick();
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (ex_valid !== 1'b0) $display("FAIL stall_hold%0d got=%0b want=0", k, ex_valid); else passed++;
        end
        alu_ready = 1;
        tick();
        total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd3) $display("FAIL stall_first v=%0b dest=%0d want 1 3", ex_valid, ex_dest); else passed++;
        tick();
        total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd4) $display("FAIL stall_second v=%0b dest=%0d want 1 4", ex_valid, ex_dest); else passed++;
        tick();
    endtask

    task automatic test_rdy_freeze();
        drive_idle(); alu_ready = 1;
        set_issue(32'd8, 4'd0, 32'd0, 4'd6);
        tick();
        rdy = 0;
        set_issue(32'd9, 4'd0, 32'd0, 4'd7);
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (ex_valid !== 1'b0) $display("FAIL rdy_hold%0d got=%0b want=0", k, ex_valid); else passed++;
        end
        drive_idle();
        tick();
        total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd6) $display("FAIL rdy_resume v=%0b dest=%0d want 1 6", ex_valid, ex_dest); else passed++;
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL rdy_no_issue got=%0b want=0", ex_valid); else passed++;
    endtask

    task automatic test_flush();
        drive_idle(); alu_ready = 1;
        for (int i = 0; i < 8; i++) begin
            set_issue(32'd0, 4'd6, 32'd0, 4'(i + 1));
            tick();
        end
        drive_idle();
        flush = 1;
        rob_ready = 1; rob_tag = 4'd6; rob_value = 32'h77;
        tick();
        drive_idle();
        total++; if (rs_full !== 1'b0 || ex_valid !== 1'b0) $display("FAIL flush_clear full=%0b v=%0b want 0 0", rs_full, ex_valid); else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (ex_valid !== 1'b0) $display("FAIL flush_quiet%0d got=%0b want=0", k, ex_valid); else passed++;
        end
        set_issue(32'd3, 4'd0, 32'd0, 4'd7);
        tick();
        drive_idle();
        tick();
        total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd7) $display("FAIL flush_reuse v=%0b dest=%0d want 1 7", ex_valid, ex_dest); else passed++;
        tick();
    endtask

    task automatic test_rst_mid();
        drive_idle(); alu_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_issue(32'd4, 4'd0, 32'd0, 4'(i + 1));
            tick();
        end
        drive_idle();
        alu_ready = 1;
        tick();
        total++; if (ex_valid !== 1'b1 || ex_dest !== 4'd1) $display("FAIL rst_mid_pre v=%0b dest=%0d want 1 1", ex_valid, ex_dest); else passed++;
        rst = 1;
        tick();
        rst = 0;
        total++; if (ex_valid !== 1'b0 || ex_dest !== 4'd0) $display("FAIL rst_mid_clear v=%0b dest=%0d want 0 0", ex_valid, ex_dest); else passed++;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (ex_valid !== 1'b0) $display("FAIL rst_mid_quiet%0d got=%0b want=0", k, ex_valid); else passed++;
        end
    endtask

    task automatic test_random();
        drive_idle();
        for (int c = 0; c < 600; c++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            alu_ready = ($urandom_range(0, 9) < 7);
            in_ready  = ($urandom_range(0, 9) < 6);
            in_name   = $urandom; in_rd = $urandom; in_imm = $urandom;
            in_vj     = $urandom; in_vk = $urandom;
            in_qj     = 4'($urandom_range(0, 5));
            in_qk     = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 5)) : 4'd0;
            in_dest   = 4'($urandom_range(1, 15));
            rob_ready = $urandom_range(0, 1); rob_tag = 4'($urandom_range(1, 5)); rob_value = $urandom;
            lsb_ready = $urandom_range(0, 1); lsb_tag = 4'($urandom_range(1, 5)); lsb_value = $urandom;
            tick();
            total++; if (ex_valid !== m_valid) $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, ex_valid, m_valid); else passed++;
            total++; if (rs_full !== model_full()) $display("FAIL rnd_full c=%0d got=%0b want=%0b", c, rs_full, model_full()); else passed++;
            if (m_valid) begin
                total++;
                if (ex_name !== m_name || ex_rd !== m_rd || ex_imm !== m_imm || ex_dest !== m_dest)
                    $display("FAIL rnd_fields c=%0d name=%h rd=%h imm=%h dest=%0d want %h %h %h %0d", c, ex_name, ex_rd, ex_imm, ex_dest, m_name, m_rd, m_imm, m_dest);
                else passed++;
                total++;
                if (ex_vj !== m_vj || ex_vk !== m_vk)
                    $display("FAIL rnd_operands c=%0d vj=%h vk=%h want %h %h", c, ex_vj, ex_vk, m_vj, m_vk);
                else passed++;
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        alu_ready = 0;
        rst = 1;
        test_reset();
        test_basic();
        test_rob_wakeup();
        test_issue_forward();
        test_full();
        test_alu_stall();
        test_rdy_freeze();
        test_flush();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
